// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, imem request/ack handshake, redirects and load-use stalls.
// Optional macro FETCH_MISALIGN_CHECK_EN: word-aligns redirect targets and raises a sticky misalign flag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Hazard_stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] addedPC_o,
  output logic        inst_valid_o,
  output logic        fetch_stall_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] added_pc_q, added_pc_d;
  logic        inst_valid_q, inst_valid_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;

  assign redirect   = jump_i | branch_i;
  assign target_raw = jump_i ? jump_target_i : branch_target_i;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign target     = {target_raw[31:2], 2'b00};
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (redirect && (target_raw[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end
`else
  assign target     = target_raw;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    inst_d         = inst_q;
    added_pc_d     = added_pc_q;
    inst_valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = target;
        end else if (!Hazard_stall_i) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (imem_ack_i) begin
          state_d = IDLE;
          if (redirect) begin
            pc_d = target;
          end else if (!Hazard_stall_i) begin
            inst_d       = imem_data_i;
            added_pc_d   = pc_q + 32'd4;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end else if (redirect) begin
          // Request must stay at the old address until memory acks it.
          saved_target_d = target;
          state_d        = FLUSH;
        end
      end
      FLUSH: begin
        if (redirect) begin
          saved_target_d = target;
        end
        if (imem_ack_i) begin
          state_d = IDLE;
          pc_d    = redirect ? target : saved_target_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      saved_target_q <= RESET_PC;
      inst_q         <= 32'h0;
      added_pc_q     <= 32'h0;
      inst_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      saved_target_q <= saved_target_d;
      inst_q         <= inst_d;
      added_pc_q     <= added_pc_d;
      inst_valid_q   <= inst_valid_d;
    end
  end

  assign imem_req_o    = (state_q == BUSY) || (state_q == FLUSH);
  assign imem_addr_o   = pc_q;
  assign inst_o        = inst_q;
  assign addedPC_o     = added_pc_q;
  assign inst_valid_o  = inst_valid_q;
  assign fetch_stall_o = ~inst_valid_q;

endmodule
